// File: rtl/mux_2to1_pkg.sv
// Shared constants and types for the mux_2to1 block.
package mux_2to1_pkg;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 16;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [CNT_W-1:0]  cnt_t;
endpackage

// File: rtl/mux_2to1_if.sv
// Operand/result bundle for mux_2to1.
// The producer side uses the master modport and the selector uses the slave modport.
interface mux_2to1_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);
   logic             Sel;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             in_valid;
   logic [WIDTH-1:0] C;
   logic [WIDTH-1:0] C_q;
   logic             out_valid;
   logic             sel_q;
   logic [CNT_W-1:0] toggle_cnt;

   modport master (
      output Sel, A, B, in_valid,
      input  C, C_q, out_valid, sel_q, toggle_cnt
   );

   modport slave (
      input  Sel, A, B, in_valid,
      output C, C_q, out_valid, sel_q, toggle_cnt
   );
endinterface

// File: rtl/mux_2to1_cap.sv
// Capture register for the selected word, and a saturating counter of Sel transitions.
module mux_2to1_cap
   import mux_2to1_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int CNT_W = mux_2to1_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sel,
   input  logic [WIDTH-1:0] d,
   input  logic             in_valid,
   output logic [WIDTH-1:0] c_q,
   output logic             sel_q,
   output logic             out_valid,
   output logic [CNT_W-1:0] toggle_cnt
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] data_reg;
   logic             sel_reg;
   logic             valid_reg;
   logic             prev_sel_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   // Capture the selected word on valid cycles; the data holds while in_valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_reg  <= '0;
         sel_reg   <= 1'b0;
         valid_reg <= 1'b0;
      end else begin
         if (in_valid) begin
            data_reg <= d;
            sel_reg  <= sel;
         end
         valid_reg <= in_valid;
      end
   end

   // Count Sel transitions. The counter saturates at all-ones and does not wrap.
   always_comb begin
      cnt_next = cnt_reg;
      if ((sel != prev_sel_reg) && (cnt_reg != CNT_MAX)) begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   // Sample Sel on every clock, independent of in_valid, for transition detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_sel_reg <= 1'b0;
         cnt_reg      <= '0;
      end else begin
         prev_sel_reg <= sel;
         cnt_reg      <= cnt_next;
      end
   end

   assign c_q        = data_reg;
   assign sel_q      = sel_reg;
   assign out_valid  = valid_reg;
   assign toggle_cnt = cnt_reg;
endmodule

// File: rtl/mux_2to1.sv
// Word-wide 2:1 selector: C = Sel ? B : A. It also provides a clocked copy and a Sel-toggle count.
// Defining MUX_2TO1_REG_OUT_EN drives C from the registered copy instead. C then has one cycle of latency.
module mux_2to1
   import mux_2to1_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int CNT_W = mux_2to1_pkg::CNT_W
) (
   input  logic      clk,
   input  logic      rst_n,
   mux_2to1_if.slave bus
);
   logic [WIDTH-1:0] sel_data;
   logic [WIDTH-1:0] c_q;

   // Combinational operand select.
   always_comb begin
      sel_data = bus.Sel ? bus.B : bus.A;
   end

   mux_2to1_cap #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_cap (
      .clk        (clk),
      .rst_n      (rst_n),
      .sel        (bus.Sel),
      .d          (sel_data),
      .in_valid   (bus.in_valid),
      .c_q        (c_q),
      .sel_q      (bus.sel_q),
      .out_valid  (bus.out_valid),
      .toggle_cnt (bus.toggle_cnt)
   );

   assign bus.C_q = c_q;

`ifdef MUX_2TO1_REG_OUT_EN
   assign bus.C = c_q;
`else
   assign bus.C = sel_data;
`endif
endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1.
// It drives a default instance and a CNT_W=4 instance from the same inputs.
// Each instance is checked against a behavioural model.
module tb_mux_2to1;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        iv = 1'b0;

   int tests = 0;
   int fails = 0;

   // model state
   logic [31:0] m_cq;
   logic        m_selq;
   logic        m_ov;
   logic        m_prev;
   int          m_cnt;
   int          m_cnt4;

   mux_2to1_if #(.WIDTH(32), .CNT_W(16)) bus ();
   mux_2to1_if #(.WIDTH(32), .CNT_W(4))  bus4 ();

   assign bus.Sel       = sel;
   assign bus.A         = a;
   assign bus.B         = b;
   assign bus.in_valid  = iv;
   assign bus4.Sel      = sel;
   assign bus4.A        = a;
   assign bus4.B        = b;
   assign bus4.in_valid = iv;

   mux_2to1 #(.WIDTH(32), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   mux_2to1 #(.WIDTH(32), .CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cq = '0; m_selq = 1'b0; m_ov = 1'b0; m_prev = 1'b0; m_cnt = 0; m_cnt4 = 0;
   endtask

   function automatic logic [31:0] exp_c();
`ifdef MUX_2TO1_REG_OUT_EN
      return m_cq;
`else
      return sel ? b : a;
`endif
   endfunction

   task automatic check_regs(input string tag);
      check({tag, ".C_q"}, bus.C_q, m_cq);
      check({tag, ".sel_q"}, {31'd0, bus.sel_q}, {31'd0, m_selq});
      check({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, m_ov});
      check({tag, ".toggle_cnt"}, {16'd0, bus.toggle_cnt}, m_cnt);
      check({tag, ".toggle_cnt4"}, {28'd0, bus4.toggle_cnt}, m_cnt4);
   endtask

   // One transaction: drive, check C, clock, update model, check registered outputs.
   task automatic step(input string tag, input logic s, input logic [31:0] va,
                       input logic [31:0] vb, input logic v);
      sel = s; a = va; b = vb; iv = v;
      #1;
      check({tag, ".C"}, bus.C, exp_c());
      @(posedge clk);
      if (v) begin
         m_cq = s ? vb : va;
         m_selq = s;
      end
      m_ov = v;
      if (s != m_prev) begin
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt4 < 15) m_cnt4++;
      end
      m_prev = s;
      #1;
      check_regs(tag);
`ifdef MUX_2TO1_REG_OUT_EN
      check({tag, ".C_reg"}, bus.C, m_cq);
`endif
      $display("[TB] %s sel=%0d a=%h b=%h v=%0d -> C_q=%h cnt=%0d cnt4=%0d",
               tag, s, va, vb, v, bus.C_q, bus.toggle_cnt, bus4.toggle_cnt);
   endtask

   initial begin
      model_reset();
      sel = 1'b0; a = 32'd29; b = 32'd13; iv = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_regs("reset");
      check("reset.C", bus.C, exp_c());
      #2 rst_n = 1'b1;

      // directed test plan
      step("basic0", 1'b0, 32'd29, 32'd13, 1'b1);
      step("sel01",  1'b1, 32'd29, 32'd13, 1'b1);
      step("sel10",  1'b0, 32'd29, 32'd13, 1'b1);
      step("novalid", 1'b0, 32'd29, 32'd13, 1'b0);
      step("hold",   1'b1, 32'd7,  32'd8,  1'b0);

      // extremes, alternating select
      for (int i = 0; i < 8; i++)
         step("extreme", i[0], 32'hFFFF_FFFF, 32'h0, 1'b1);

      // 20 toggles drive the 4-bit counter into saturation
      for (int i = 0; i < 20; i++)
         step("sat", ~sel, $urandom, $urandom, 1'($urandom_range(0, 1)));
      check("sat.cnt4_final", {28'd0, bus4.toggle_cnt}, 32'd15);

      // equal operands: same output for both selects, toggles still counted
      step("eq0", 1'b0, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b1);
      step("eq1", 1'b1, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b1);

      // random traffic
      for (int i = 0; i < 200; i++)
         step("rand", 1'($urandom_range(0, 1)), $urandom, $urandom,
              1'($urandom_range(0, 3) != 0));

      // asynchronous reset mid-stream
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_regs("midrst");
      sel = ~sel; a = $urandom; b = $urandom;
      #1;
      check("midrst.C", bus.C, exp_c());
      #2 rst_n = 1'b1;

      // first edge after reset with Sel=1 counts as a toggle
      step("postrst", 1'b1, 32'd29, 32'd13, 1'b1);
      for (int i = 0; i < 20; i++)
         step("rand2", 1'($urandom_range(0, 1)), $urandom, $urandom,
              1'($urandom_range(0, 1)));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
